// File: rtl/cla_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : cla_display_scanner
// Brief    : Time-multiplexed 4-digit seven-segment driver showing A, B (hex)
//            and the decimal value of {Cout,Sum}.
// Revision : 1.0
// ============================================================================
module cla_display_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] Sum,
    input  logic       Cout,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int                 c_pre_w   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(REFRESH_DIV - 1);
    localparam logic [c_pre_w-1:0] c_pre_one = c_pre_w'(1);

    localparam logic [3:0] c_an_off  = 4'b1111;
    localparam logic [3:0] c_an_d0   = 4'b1110;
    localparam logic [3:0] c_an_d1   = 4'b1101;
    localparam logic [3:0] c_an_d2   = 4'b1011;
    localparam logic [3:0] c_an_d3   = 4'b0111;
    localparam logic [6:0] c_seg_off = 7'b1111111;

    logic [c_pre_w-1:0] r_pre;
    logic               w_tick;
    logic [1:0]         r_idx;

    logic [3:0]         r_a;
    logic [3:0]         r_b;
    logic [3:0]         r_sum;
    logic               r_cout;

    logic [4:0]         w_total;
    logic [1:0]         w_tens;
    logic [3:0]         w_ones;

    logic [3:0]         w_an;
    logic [6:0]         w_seg;
    logic               w_dp;

    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_tick = (r_pre == c_pre_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_pre_one;
        end
    end

    // Snapshot only on the 3->0 digit transition so a scan never mixes old and new inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= 2'd0;
            r_a    <= 4'd0;
            r_b    <= 4'd0;
            r_sum  <= 4'd0;
            r_cout <= 1'b0;
        end else if (w_tick) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_a    <= A;
                r_b    <= B;
                r_sum  <= Sum;
                r_cout <= Cout;
            end
        end
    end

    // Ones stay below 10, so subtracting in the low nibble is exact.
    assign w_total = {r_cout, r_sum};

    always_comb begin
        w_tens = 2'd0;
        w_ones = r_sum;
        if (w_total >= 5'd30) begin
            w_tens = 2'd3;
            w_ones = r_sum - 4'd14;
        end else if (w_total >= 5'd20) begin
            w_tens = 2'd2;
            w_ones = r_sum - 4'd4;
        end else if (w_total >= 5'd10) begin
            w_tens = 2'd1;
            w_ones = r_sum - 4'd10;
        end
    end

    always_comb begin
        w_an  = c_an_off;
        w_seg = c_seg_off;
        w_dp  = 1'b1;
        case (r_idx)
            2'd0: begin
                w_an  = c_an_d0;
                w_seg = enc(w_ones);
            end
            2'd1: begin
                w_an  = c_an_d1;
                w_seg = (w_tens == 2'd0) ? c_seg_off : enc({2'b00, w_tens});
            end
            2'd2: begin
                w_an  = c_an_d2;
                w_seg = enc(r_b);
                w_dp  = 1'b0;
            end
            default: begin
                w_an  = c_an_d3;
                w_seg = enc(r_a);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= c_an_off;
            r_seg <= c_seg_off;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_cla_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_display_scanner
// Brief    : Self-checking bench for cla_display_scanner with REFRESH_DIV=4.
// Revision : 1.0
// ============================================================================
module tb_cla_display_scanner;

    localparam int RD = 4;

    localparam logic [6:0] FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] A     = 4'd0;
    logic [3:0] B     = 4'd0;
    logic [3:0] Sum   = 4'd0;
    logic       Cout  = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    cla_display_scanner #(.REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Sum   (Sum),
        .Cout  (Cout),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: digit position from elapsed edges, decimal split by division.
    function automatic int pos_of(input int k);
        return (k / RD) % 4;
    endfunction

    function automatic logic [3:0] anode_of(input int p);
        return ~(4'b0001 << p);
    endfunction

    function automatic logic [6:0] glyph_of(input int p, input logic [3:0] a,
                                            input logic [3:0] b, input logic [3:0] s,
                                            input logic c);
        int t;
        t = int'(c) * 16 + int'(s);
        case (p)
            0:       return FONT[t % 10];
            1:       return (t / 10 == 0) ? 7'b1111111 : FONT[t / 10];
            2:       return FONT[b];
            default: return FONT[a];
        endcase
    endfunction

    int         k = 0;
    logic [3:0] ma = 4'd0, mb = 4'd0, ms = 4'd0;
    logic       mc = 1'b0;
    logic [3:0] exp_an  = 4'b1111;
    logic [6:0] exp_seg = 7'b1111111;
    logic       exp_dp  = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= 0;
            ma      <= 4'd0;
            mb      <= 4'd0;
            ms      <= 4'd0;
            mc      <= 1'b0;
            exp_an  <= 4'b1111;
            exp_seg <= 7'b1111111;
            exp_dp  <= 1'b1;
        end else begin
            exp_an  <= anode_of(pos_of(k));
            exp_seg <= glyph_of(pos_of(k), ma, mb, ms, mc);
            exp_dp  <= (pos_of(k) != 2);
            k       <= k + 1;
            if ((k + 1) % (4 * RD) == 0) begin
                ma <= A;
                mb <= B;
                ms <= Sum;
                mc <= Cout;
            end
        end
    end

    logic [3:0] prev_an = 4'b1111;
    int         run     = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_an",  32'(an),  32'(exp_an));
            check("model_seg", 32'(seg), 32'(exp_seg));
            check("model_dp",  32'(dp),  32'(exp_dp));
            if (!rst_n) begin
                prev_an <= 4'b1111;
                run     <= 0;
            end else begin
                check("one_anode_low", 32'($countones(~an) <= 1), 32'd1);
                if (an != prev_an && prev_an != 4'b1111) begin
                    check("dwell", 32'(run), 32'(RD));
                    check("order", 32'(an), 32'({prev_an[2:0], prev_an[3]}));
                end
                prev_an <= an;
                run     <= (an == prev_an) ? run + 1 : 1;
            end
        end
    end

    task automatic wait_an(input logic [3:0] pat);
        int n = 0;
        @(negedge clk);
        while (an !== pat && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (an !== pat) check("wait_timeout", 32'(an), 32'(pat));
    endtask

    task automatic wait_boundary();
        wait_an(4'b0111);
        wait_an(4'b1110);
    endtask

    // Call while the first cycle of digit0 is on display.
    task automatic check_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        check({tag, "_an0"},  32'(an),  32'(4'b1110));
        check({tag, "_ones"}, 32'(seg), 32'(s0));
        wait_an(4'b1101);
        check({tag, "_tens"}, 32'(seg), 32'(s1));
        wait_an(4'b1011);
        check({tag, "_b"},    32'(seg), 32'(s2));
        check({tag, "_dp"},   32'(dp),  32'd0);
        wait_an(4'b0111);
        check({tag, "_a"},    32'(seg), 32'(s3));
    endtask

    task automatic apply(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] s, input logic c);
        @(negedge clk);
        A = a; B = b; Sum = s; Cout = c;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_an",  32'(an),  32'(4'b1111));
        check("rst_seg", 32'(seg), 32'(7'b1111111));
        check("rst_dp",  32'(dp),  32'd1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_an",  32'(an),  32'(4'b1110));
        check("first_seg", 32'(seg), 32'(7'b1000000));

        // Asynchronous reset in the middle of a scan.
        wait_an(4'b1011);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_an",  32'(an),  32'(4'b1111));
        check("midrst_seg", 32'(seg), 32'(7'b1111111));
        check("midrst_dp",  32'(dp),  32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_an",  32'(an),  32'(4'b1110));
        check("rel_seg", 32'(seg), 32'(7'b1000000));

        apply(4'h4, 4'h2, 4'h6, 1'b0);
        wait_boundary();
        check_scan("t6", 7'b0000010, 7'b1111111, 7'b0100100, 7'b0011001);

        apply(4'hF, 4'h5, 4'h4, 1'b1);
        wait_boundary();
        check_scan("t20", 7'b1000000, 7'b0100100, 7'b0010010, 7'b0001110);

        apply(4'h7, 4'h7, 4'hE, 1'b0);
        wait_boundary();
        check_scan("t14", 7'b0011001, 7'b1111001, 7'b1111000, 7'b1111000);

        apply(4'hF, 4'hF, 4'hE, 1'b1);
        wait_boundary();
        check_scan("t30", 7'b1000000, 7'b0110000, 7'b0001110, 7'b0001110);

        // Inputs change mid-scan; only the following scan may reflect them.
        apply(4'h1, 4'h1, 4'h2, 1'b0);
        wait_boundary();
        check("tear_ones", 32'(seg), 32'(7'b0100100));
        wait_an(4'b1101);
        A = 4'h8; B = 4'h8; Sum = 4'h0; Cout = 1'b1;
        check("tear_tens", 32'(seg), 32'(7'b1111111));
        wait_an(4'b1011);
        check("tear_b", 32'(seg), 32'(7'b1111001));
        wait_an(4'b0111);
        check("tear_a", 32'(seg), 32'(7'b1111001));
        wait_an(4'b1110);
        check_scan("t16", 7'b0000010, 7'b1111001, 7'b0000000, 7'b0000000);

        for (int i = 0; i < 24; i++) begin
            apply(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        repeat (3 * 4 * RD) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cla_display_scanner.md
Name: cla_display_scanner

Overview:
Downstream stage of the 4-bit carry-lookahead adder. Takes the adder's operands and result and drives a 4-digit, common-anode, time-multiplexed seven-segment display:
- digit3 = A in hex
- digit2 = B in hex
- digit1/digit0 = decimal tens/ones of {Cout,Sum}

Inputs are snapshotted once per full scan so a digit never shows a torn value.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (1 kHz/digit at 100 MHz); legal range 1..2^20.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
A  input  4  adder operand A
B  input  4  adder operand B
Sum  input  4  adder sum
Cout  input  1  adder carry out
an  output  4  digit anodes, active-low, an[0]=rightmost
seg  output  7  segments, active-low, seg[0]=a … seg[6]=g
dp  output  1  decimal point, active-low

Behaviour:
- Reset (rst_n=0, asynchronous, any time, including mid-scan):
  - prescaler=0, idx=0, snapshot {A,B,Sum,Cout}=0
  - an=4'b1111, seg=7'b1111111, dp=1, all immediately
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick=1 in the cycle where prescaler==REFRESH_DIV-1. With REFRESH_DIV=1, tick is 1 every cycle.
- On a rising edge with tick=1:
  - idx <= (idx+1) mod 4
  - if idx==3, snapshot <= current inputs
  - Snapshot is taken on no other edge, so input changes mid-scan are ignored until the 3→0 transition.
- Output stage is registered. Every edge: an/seg <= decode(idx, snapshot), i.e. outputs lag idx by exactly 1 cycle.
  - First edge after reset release shows digit0 = '0'.
  - Each anode is low for exactly REFRESH_DIV consecutive cycles.
  - At most one anode is low, ever.
- Result arithmetic: total = {Cout,Sum}, 5 bits, range 0..31.
  - tens = 3 if total≥30, 2 if ≥20, 1 if ≥10, else 0
  - ones = total − 10·tens
  - Comparator/subtract only; no divider.
- Digit map:
  - idx0: an=1110, seg=enc(ones)
  - idx1: an=1101, seg=enc(tens), or blank 1111111 when tens==0; anode still driven
  - idx2: an=1011, seg=enc(B)
  - idx3: an=0111, seg=enc(A)
- dp=0 only while idx2 is displayed (separates the operand pair from the result); otherwise 1.
- enc (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Inputs are assumed quasi-static board values; no synchronizers are required inside this block.

Test Plan (REFRESH_DIV=4):
1. Reset: assert rst_n=0 mid-scan while an=1011 → an=1111, seg=1111111, dp=1 within the same timestep. After release, first edge → an=1110, seg=1000000.
2. A=4,B=2,Sum=6,Cout=0, then wait past the first idx3→0 tick →
   - an=1110: seg=0000010
   - an=1101: seg=1111111
   - an=1011: seg=0100100, dp=0
   - an=0111: seg=0011001
3. A=F,B=5,Sum=4,Cout=1 (total 20) →
   - ones: 1000000
   - tens: 0100100
   - B: 0010010
   - A: 0001110
4. A=7,B=7,Sum=E,Cout=0 (total 14) → ones 0011001, tens 1111001. Also A=F,B=F,Sum=E,Cout=1 (total 30) → ones 1000000, tens 0110000.
5. Tearing: snapshot A=1,B=1,Sum=2, then change to A=8,B=8,Sum=0,Cout=1 while idx=1 → remaining digits of that scan still show 2/blank/1/1; the next scan shows ones '6', tens '1', B '8', A '8'.
6. Timing: over 3 full scans, check:
   - each anode low exactly 4 consecutive cycles
   - sequence 1110→1101→1011→0111→1110
   - never more than one anode low
   - an changes exactly 1 cycle after idx changes
